csa_pipe_skip_adder: RTL and testbench

- Parametrised, pipelined carry-skip adder/subtractor. Generalises the fixed 4-bit carry-skip block to WIDTH bits split into BLK-bit skip groups.
- Each skip group occupies one pipeline stage, so the carry chain is broken per group.
- Valid/ready handshakes on input and output let it sit in streaming datapaths, such as ALU back-ends and accumulators, at one result per cycle.

---
 rtl/csa_pipe_skip_adder_if.sv | 27 ++
 rtl/csa_pipe_skip_adder.sv | 112 +++++++++++
 tb/tb_csa_pipe_skip_adder.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/csa_pipe_skip_adder_if.sv
// Operand/result stream bundle for the pipelined carry-skip adder.
// master drives operands and consumes results; slave is the adder.
interface csa_pipe_skip_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/csa_pipe_skip_adder.sv
// Pipelined carry-skip adder/subtractor: one BLK-bit skip group per stage,
// valid/ready streaming with a global stall enable.

// Per-group ripple adder; the skip mux sits in the parent so it stays visible.
module csa_skip_grp #(
  parameter int BLK = 4
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           ci,
  output logic [BLK-1:0] s,
  output logic           rc,
  output logic           cm,
  output logic           p
);
  logic [BLK:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < BLK; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign rc = c[BLK];
  assign cm = c[BLK-1];
  assign p  = &(a ^ b);
endmodule

module csa_pipe_skip_adder #(
  parameter int WIDTH = 16,
  parameter int BLK   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  csa_pipe_skip_adder_if.slave  s
);
  localparam int NBLK = WIDTH / BLK;

  // a/b ride along as skew registers; s accumulates finished low groups
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
    logic             c;
    logic             cm;
  } stg_t;

  stg_t stg_d [NBLK];
  stg_t stg_q [NBLK];
  stg_t nxt   [NBLK];

  logic [NBLK:1]                vld_q;
  logic [NBLK:0]                vld_pipe;
  logic                         en;
  logic [NBLK-1:0][BLK-1:0]     gs;
  logic [NBLK-1:0]              grc, gcm, gp, gco;

  assign vld_pipe   = {vld_q, s.in_valid};
  assign en         = !vld_pipe[NBLK] || s.out_ready;
  assign s.in_ready = en;

  always_comb begin
    stg_d[0].a  = s.a;
    stg_d[0].b  = s.sub ? ~s.b : s.b;
    stg_d[0].s  = '0;
    stg_d[0].c  = s.sub | s.cin;
    stg_d[0].cm = 1'b0;
    for (int k = 1; k < NBLK; k++) stg_d[k] = stg_q[k-1];
  end

  for (genvar k = 0; k < NBLK; k++) begin : g_stg
    csa_skip_grp #(.BLK(BLK)) u_grp (
      .a  (stg_d[k].a[k*BLK +: BLK]),
      .b  (stg_d[k].b[k*BLK +: BLK]),
      .ci (stg_d[k].c),
      .s  (gs[k]),
      .rc (grc[k]),
      .cm (gcm[k]),
      .p  (gp[k])
    );
    // Skip mux: a fully-propagating group forwards its incoming carry.
    assign gco[k] = gp[k] ? stg_d[k].c : grc[k];
  end

  always_comb begin
    for (int k = 0; k < NBLK; k++) begin
      nxt[k]                  = stg_d[k];
      nxt[k].s[k*BLK +: BLK]  = gs[k];
      nxt[k].c                = gco[k];
      nxt[k].cm               = gcm[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int k = 0; k < NBLK; k++) stg_q[k] <= '0;
    end else if (en) begin
      vld_q <= vld_pipe[NBLK-1:0];
      for (int k = 0; k < NBLK; k++) stg_q[k] <= nxt[k];
    end
  end

  assign s.out_valid = vld_q[NBLK];
  assign s.sum       = stg_q[NBLK-1].s;
  assign s.cout      = stg_q[NBLK-1].c;
  assign s.ovf       = stg_q[NBLK-1].c ^ stg_q[NBLK-1].cm;
endmodule

// File: tb/tb_csa_pipe_skip_adder.sv
// Directed and random checks of the 16-bit, 4-group pipelined carry-skip adder.
module tb_csa_pipe_skip_adder;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  csa_pipe_skip_adder_if #(.WIDTH(16)) bus();
  csa_pipe_skip_adder #(.WIDTH(16), .BLK(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s     (bus)
  );

  int npass = 0;
  int nfail = 0;
  int ntot  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [17:0] model(input logic [15:0] a_, input logic [15:0] b_,
                                        input logic cin_, input logic sub_);
    logic [15:0] be;
    logic        c0;
    logic [16:0] r;
    logic [15:0] lo;
    be = sub_ ? ~b_ : b_;
    c0 = sub_ | cin_;
    r  = {1'b0, a_} + {1'b0, be} + 17'(c0);
    lo = {1'b0, a_[14:0]} + {1'b0, be[14:0]} + 16'(c0);
    return {r[16] ^ lo[15], r};
  endfunction

  // One isolated beat; checks exact latency of 4 and the result fields.
  task automatic single(input string tag, input logic [15:0] a_, input logic [15:0] b_,
                        input logic cin_, input logic sub_,
                        input logic [15:0] es, input logic ec, input logic eo);
    bus.a = a_; bus.b = b_; bus.cin = cin_; bus.sub = sub_;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    chk({tag, "_early"}, 32'(bus.out_valid), 32'd0);
    tick();
    chk({tag, "_vld"},  32'(bus.out_valid), 32'd1);
    chk({tag, "_sum"},  32'(bus.sum),       32'(es));
    chk({tag, "_cout"}, 32'(bus.cout),      32'(ec));
    chk({tag, "_ovf"},  32'(bus.ovf),       32'(eo));
    tick();
    chk({tag, "_gone"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    int sent, rcv, seen;
    int exp_cyc [8];
    logic exp_vld, exp_rdy;
    logic [17:0] q[$];

    exp_cyc = '{4, 8, 9, 10, 11, 12, 13, 14};

    // Reset
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk("rst_vld", 32'(bus.out_valid), 32'd0);
    repeat (2) tick();
    chk("rst_sum",  32'(bus.sum),  32'd0);
    chk("rst_cout", 32'(bus.cout), 32'd0);
    chk("rst_ovf",  32'(bus.ovf),  32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_rdy", 32'(bus.in_ready), 32'd1);
    tick();

    // Full-skip: every group fully propagates
    bus.a = 16'hFFFF; bus.b = 16'h0000; bus.cin = 1'b1; bus.sub = 1'b0;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    #1;
    chk("skip_p0", 32'(dut.gp[0]), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("skip_p1", 32'(dut.gp[1]), 32'd1);
    tick();
    chk("skip_p2", 32'(dut.gp[2]), 32'd1);
    tick();
    chk("skip_p3", 32'(dut.gp[3]), 32'd1);
    chk("skip_early", 32'(bus.out_valid), 32'd0);
    tick();
    chk("skip_vld",  32'(bus.out_valid), 32'd1);
    chk("skip_sum",  32'(bus.sum),       32'h0000);
    chk("skip_cout", 32'(bus.cout),      32'd1);
    chk("skip_ovf",  32'(bus.ovf),       32'd0);
    tick();
    chk("skip_gone", 32'(bus.out_valid), 32'd0);

    // Overflow and subtract vectors
    single("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    single("ovf_neg", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    single("sub_neg", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    single("sub_pos", 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);
    single("sub_zero", 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    single("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    single("add_cin", 16'h00FF, 16'h0F00, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0);

    // Streaming 8 beats, consumer stalls on cycles 5..7
    sent = 0; rcv = 0;
    for (int c = 0; c < 18; c++) begin
      exp_rdy = !(c >= 5 && c <= 7);
      exp_vld = (c >= 4 && c <= 14);
      bus.out_ready = exp_rdy;
      bus.in_valid  = (sent < 8);
      bus.a   = 16'(sent);
      bus.b   = 16'(sent * 16'h1000);
      bus.cin = 1'b0; bus.sub = 1'b0;
      #1;
      chk($sformatf("strm_rdy_c%0d", c), 32'(bus.in_ready),  32'(exp_rdy));
      chk($sformatf("strm_vld_c%0d", c), 32'(bus.out_valid), 32'(exp_vld));
      if (c >= 5 && c <= 7)
        chk($sformatf("strm_hold_c%0d", c), 32'(bus.sum), 32'h1001);
      if (exp_vld && exp_rdy && rcv < 8) begin
        chk($sformatf("strm_sum%0d", rcv), 32'(bus.sum), 32'(16'(rcv) + 16'(rcv * 16'h1000)));
        chk($sformatf("strm_cyc%0d", rcv), 32'(c), 32'(exp_cyc[rcv]));
        chk($sformatf("strm_ovf%0d", rcv), 32'(bus.ovf), 32'd0);
        rcv++;
      end
      if (bus.in_valid && exp_rdy) sent++;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    chk("strm_count", 32'(rcv), 32'd8);

    // Reset while three beats are in flight
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.a = 16'(i + 1); bus.b = 16'h0100; bus.in_valid = 1'b1;
      tick();
    end
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", 32'(bus.out_valid), 32'd0);
    tick();
    chk("mid_rst_vld2", 32'(bus.out_valid), 32'd0);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.out_valid) seen++;
    end
    chk("mid_rst_stale", 32'(seen), 32'd0);
    single("mid_rst_new", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);

    // Async reset drops a held result without a clock edge
    bus.out_ready = 1'b0;
    bus.a = 16'h0001; bus.b = 16'h0001; bus.cin = 1'b0; bus.sub = 1'b0; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (5) tick();
    chk("hold_vld", 32'(bus.out_valid), 32'd1);
    chk("hold_sum", 32'(bus.sum),       32'h0002);
    chk("hold_rdy", 32'(bus.in_ready),  32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_vld", 32'(bus.out_valid), 32'd0);
    chk("async_sum", 32'(bus.sum),       32'd0);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    tick();

    // Random regression against the reference model
    for (int c = 0; c < 10000; c++) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.a         = 16'($urandom);
      bus.b         = 16'($urandom);
      bus.cin       = 1'($urandom_range(0, 1));
      bus.sub       = 1'($urandom_range(0, 1));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) chk("rnd_extra", 32'd1, 32'd0);
        else chk("rnd", 32'({bus.ovf, bus.cout, bus.sum}), 32'(q.pop_front()));
      end
      if (bus.in_valid && bus.in_ready) q.push_back(model(bus.a, bus.b, bus.cin, bus.sub));
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (bus.out_valid) begin
        if (q.size() == 0) chk("rnd_extra", 32'd1, 32'd0);
        else chk("rnd_drain", 32'({bus.ovf, bus.cout, bus.sum}), 32'(q.pop_front()));
      end
      @(posedge clk);
      #1;
    end
    chk("rnd_left", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
